ps2_key_decoder: RTL

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

---
 rtl/ps2_key_decoder.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 keyboard receiver: filters the device clock, deframes scan codes, tracks E0/F0 prefixes
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   ps2_clk      raw PS/2 clock from device (asynchronous, receive only)
//   ps2_data     raw PS/2 data from device (asynchronous, receive only)
//   keyboardCode last accepted non-prefix scan code
//   ps2_ready    one-cycle pulse when keyboardCode/extended/released update
//   extended     accepted code was preceded by E0
//   released     accepted code was preceded by F0
//   frame_err    one-cycle pulse on bad start/parity/stop or timeout
module ps2_key_decoder #(
    parameter int FILT_LEN = 4,
    parameter int TIMEOUT  = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keyboardCode,
    output logic       ps2_ready,
    output logic       extended,
    output logic       released,
    output logic       frame_err
);

    localparam int FW    = $clog2(FILT_LEN + 1);
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [FW-1:0]    FILT_LAST = FW'(FILT_LEN - 1);
    localparam logic [TMO_W-1:0] TMO_LOAD  = TMO_W'(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    state_t           r_state, w_state_next;
    logic             r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic             r_clk_filt;
    logic [FW-1:0]    r_filt_cnt;
    logic [7:0]       r_shift;
    logic [2:0]       r_bit_cnt;
    logic             r_parity;
    logic             r_ext, r_brk;
    logic [TMO_W-1:0] r_tmo_cnt;
    logic [7:0]       r_code;
    logic             r_ready, r_extended, r_released, r_frame_err;

    logic w_fall, w_data, w_tmo_expire, w_stop_done, w_frame_ok;

    // The filtered clock falls on the FILT_LEN-th consecutive low sample;
    // the edge is flagged combinationally so data is sampled on that same cycle.
    assign w_fall       = r_clk_filt && !r_clk_s2 && (r_filt_cnt == FILT_LAST);
    assign w_data       = r_dat_s2;
    assign w_tmo_expire = (r_state != S_IDLE) && !w_fall && (r_tmo_cnt == TMO_W'(1));
    assign w_stop_done  = (r_state == S_STOP) && w_fall;
    // Odd parity: data bits plus parity bit must contain an odd number of ones.
    assign w_frame_ok   = w_data && (^{r_shift, r_parity});

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (w_fall && !w_data) w_state_next = S_DATA;
            S_DATA:   if (w_fall && r_bit_cnt == 3'd7) w_state_next = S_PARITY;
            S_PARITY: if (w_fall) w_state_next = S_STOP;
            S_STOP:   if (w_fall) w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
        if (w_tmo_expire) w_state_next = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_clk_s1    <= 1'b1;
            r_clk_s2    <= 1'b1;
            r_dat_s1    <= 1'b1;
            r_dat_s2    <= 1'b1;
            r_clk_filt  <= 1'b1;
            r_filt_cnt  <= '0;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_parity    <= 1'b0;
            r_ext       <= 1'b0;
            r_brk       <= 1'b0;
            r_tmo_cnt   <= '0;
            r_code      <= 8'h00;
            r_ready     <= 1'b0;
            r_extended  <= 1'b0;
            r_released  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_clk_s1    <= ps2_clk;
            r_clk_s2    <= r_clk_s1;
            r_dat_s1    <= ps2_data;
            r_dat_s2    <= r_dat_s1;
            r_ready     <= 1'b0;
            r_frame_err <= 1'b0;

            if (r_clk_s2 != r_clk_filt) begin
                if (r_filt_cnt == FILT_LAST) begin
                    r_clk_filt <= r_clk_s2;
                    r_filt_cnt <= '0;
                end else begin
                    r_filt_cnt <= r_filt_cnt + FW'(1);
                end
            end else begin
                r_filt_cnt <= '0;
            end

            // Timeout counter: idle holds at zero, any edge inside a frame reloads it.
            if (w_state_next == S_IDLE)
                r_tmo_cnt <= '0;
            else if (w_fall)
                r_tmo_cnt <= TMO_LOAD;
            else if (r_tmo_cnt != '0)
                r_tmo_cnt <= r_tmo_cnt - TMO_W'(1);

            if (w_tmo_expire) begin
                r_frame_err <= 1'b1;
                r_ext       <= 1'b0;
                r_brk       <= 1'b0;
                r_shift     <= '0;
                r_bit_cnt   <= '0;
            end else if (w_fall) begin
                case (r_state)
                    S_IDLE: begin
                        if (!w_data) begin
                            r_shift   <= '0;
                            r_bit_cnt <= '0;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                    end
                    S_DATA: begin
                        r_shift   <= {w_data, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                    end
                    S_PARITY: r_parity <= w_data;
                    S_STOP: begin
                        if (w_frame_ok) begin
                            if (r_shift == 8'hE0) begin
                                r_ext <= 1'b1;
                            end else if (r_shift == 8'hF0) begin
                                r_brk <= 1'b1;
                            end else begin
                                r_code     <= r_shift;
                                r_extended <= r_ext;
                                r_released <= r_brk;
                                r_ready    <= 1'b1;
                                r_ext      <= 1'b0;
                                r_brk      <= 1'b0;
                            end
                        end else begin
                            r_frame_err <= 1'b1;
                            r_ext       <= 1'b0;
                            r_brk       <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign keyboardCode = r_code;
    assign ps2_ready    = r_ready;
    assign extended     = r_extended;
    assign released     = r_released;
    assign frame_err    = r_frame_err;

endmodule
